// File: rtl/grc_pkg.sv
// grc_pkg: shared state encoding and mode constants for the golden response checker.
package grc_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic MODE_LEARN = 1'b0;
    localparam logic MODE_CHECK = 1'b1;
endpackage

// File: rtl/grc_golden_table.sv
// grc_golden_table: per-vector golden response store with learned flags.
// One synchronous write port, one asynchronous read port on the same address.
module grc_golden_table
    import grc_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             i_we,
    input  logic [N_IN-1:0]  i_addr,
    input  logic [N_OUT-1:0] i_wdata,
    output logic [N_OUT-1:0] o_rdata,
    output logic             o_learned
);
    localparam int D = 2 ** N_IN;

    logic [N_OUT-1:0] r_gold [D];
    logic [D-1:0]     r_learned;

    always_ff @(posedge CK) begin
        if (reset) begin
            for (int i = 0; i < D; i++) r_gold[i] <= '0;
            r_learned <= '0;
        end else if (i_we) begin
            r_gold[i_addr]    <= i_wdata;
            r_learned[i_addr] <= 1'b1;
        end
    end

    assign o_rdata   = r_gold[i_addr];
    assign o_learned = r_learned[i_addr];
endmodule

// File: rtl/golden_response_checker.sv
// golden_response_checker: learns golden responses over an exhaustive vector sweep,
// then checks later sweeps against them and flags any deviation as trojan behaviour.
module golden_response_checker
    import grc_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1,
    parameter int CNT_W = 8
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [N_IN-1:0]  vec_in,
    input  logic [N_OUT-1:0] resp_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             first_bad_vld,
    output logic [N_IN-1:0]  first_bad_vec,
    output logic             trojan_flag
);
    localparam int D = 2 ** N_IN;

    state_t           r_state, w_next;
    logic             r_mode;
    logic [D-1:0]     r_seen, w_onehot, w_seen_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fbv;
    logic [N_IN-1:0]  r_fbvec;
    logic             w_acc, w_start, w_mis, w_learned;
    logic [N_OUT-1:0] w_gold;

    grc_golden_table #(.N_IN(N_IN), .N_OUT(N_OUT)) u_table (
        .CK       (CK),
        .reset    (reset),
        .i_we     (w_acc && r_mode == MODE_LEARN),
        .i_addr   (vec_in),
        .i_wdata  (resp_in),
        .o_rdata  (w_gold),
        .o_learned(w_learned)
    );

    assign vec_ready  = (r_state == RUN);
    assign w_acc      = vec_valid & vec_ready;
    assign w_start    = start & (r_state != RUN);
    assign w_mis      = w_acc & (r_mode == MODE_CHECK) & (!w_learned | (w_gold != resp_in));
    assign w_seen_nxt = r_seen | w_onehot;

    always_comb begin
        w_onehot         = '0;
        w_onehot[vec_in] = 1'b1;
    end

    // The accept that completes the bitmap moves to DONE on the same edge.
    always_comb begin
        w_next = r_state;
        w_next = w_start ? RUN : (w_acc && &w_seen_nxt) ? DONE : r_state;
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            r_state <= IDLE;
            r_mode  <= MODE_LEARN;
            r_seen  <= '0;
            r_cnt   <= '0;
            r_fbv   <= 1'b0;
            r_fbvec <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_mode  <= mode;
                r_seen  <= '0;
                r_cnt   <= '0;
                r_fbv   <= 1'b0;
                r_fbvec <= '0;
            end else if (w_acc) begin
                r_seen <= w_seen_nxt;
                if (w_mis) begin
                    r_cnt <= (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
                    if (!r_fbv) begin
                        r_fbv   <= 1'b1;
                        r_fbvec <= vec_in;
                    end
                end
            end
        end
    end

    assign busy          = (r_state == RUN);
    assign done          = (r_state == DONE);
    assign mismatch_cnt  = r_cnt;
    assign first_bad_vld = r_fbv;
    assign first_bad_vec = r_fbvec;
    assign trojan_flag   = done & (r_mode == MODE_CHECK) & (|r_cnt);
endmodule
